pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Issues per-register write-enables and bubble flushes; detects load-use hazards; resolves branches and jumps carried in EX/MEM.
- Runs a handshake with a multi-cycle data memory and halts the pipeline when the finish marker reaches WB.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- MEM_TIMEOUT, 255, maximum number of MEM_WAIT cycles before mem_err is raised; range 1..255.

Ports:
- clk  in  1  pipeline clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idex_memrd  in  1  the instruction in ID/EX is a load.
- idex_rt  in  5  destination (rt) of the instruction in ID/EX.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- exmem_memrd  in  1  load in EX/MEM.
- exmem_memwr  in  1  store in EX/MEM.
- exmem_bbeq, exmem_bbne, exmem_bblez, exmem_bbgtz, exmem_jump  in  1 each  branch/jump controls in EX/MEM.
- exmem_zero, exmem_negative  in  1 each  ALU flags in EX/MEM.
- dmem_ready  in  1  data memory completes the current access this cycle.
- memwb_fin  in  1  finish marker valid in MEM/WB.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all zero) instead of the input; flush overrides we.
- pcsrc  out  2  next-PC select: 00 = PC+4, 01 = branaddr, 10 = jmpaddr.
- dmem_req  out  1  data memory access request.
- halted  out  1  pipeline frozen after finish.
- mem_err  out  1  memory timeout flag; sticky.
- stall_cnt  out  CNT_W  count of cycles with pc_we = 0 while not halted.
- flush_cnt  out  CNT_W  count of taken redirects.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN, halted = 0, mem_err = 0, counters = 0, wait counter = 0.
  - While rst_n is low, all we, flush and dmem_req outputs are forced to 0 and pcsrc = 00.
- States:
  - RUN, MEM_WAIT, HALT.
  - we, flush, pcsrc and dmem_req are combinational from state and inputs.
  - halted and mem_err are registered.
- mem_op = exmem_memrd | exmem_memwr.
- taken = (bbeq & zero) | (bbne & ~zero) | (bblez & (zero | negative)) | (bbgtz & ~zero & ~negative) | jump.
- load_use = idex_memrd & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
- RUN, evaluated in priority order:
  1. memwb_fin: all we = 0; next state HALT; halted = 1 from the next cycle. fin takes precedence over every other event in the same cycle.
  2. mem_op & ~dmem_ready: dmem_req = 1; all we = 0; next state MEM_WAIT; wait counter = 1.
  3. mem_op & dmem_ready: dmem_req = 1; all we = 1; single-cycle access, no stall. Then apply rules 4 and 5 in the same cycle.
  4. taken: all we = 1; ifid_flush = idex_flush = exmem_flush = 1; pcsrc = 10 if exmem_jump, else 01; flush_cnt += 1. A simultaneous load_use is ignored because the dependent instruction is flushed.
  5. load_use: pc_we = ifid_we = 0; idex_flush = 1; all other we = 1. Inserts exactly one bubble.
  6. Otherwise: all we = 1, no flushes, pcsrc = 00.
- MEM_WAIT:
  - dmem_req held at 1; all we = 0.
  - Wait counter increments each cycle.
  - On dmem_ready: behave exactly as RUN rule 3 (including branch/load-use evaluation) and return to RUN.
  - If the wait counter reaches MEM_TIMEOUT without dmem_ready: mem_err = 1; next state HALT.
- HALT:
  - All we = 0, flushes = 0, dmem_req = 0.
  - halted = 1; remains until rst_n is asserted.
- Counters:
  - stall_cnt increments in any cycle with pc_we = 0 and state != HALT, including the cycle that enters HALT.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT aborts the access: dmem_req drops immediately and the state returns to RUN.

Test Plan:
1. Load-use: idex_memrd = 1, idex_rt = 5, ifid_rs = 5 for one cycle -> pc_we = ifid_we = 0, idex_flush = 1 that cycle; stall_cnt = 1; with the same stimulus and idex_rt = 0 -> no stall.
2. Branch: exmem_bbeq = 1, zero = 1 -> pcsrc = 01, ifid/idex/exmem flushes = 1, flush_cnt = 1. With exmem_bbne = 1, zero = 1 -> pcsrc = 00 and no flush. exmem_jump = 1 -> pcsrc = 10.
3. Slow memory: exmem_memrd = 1, dmem_ready low for 3 cycles then high -> dmem_req high for 4 cycles, all we = 0 for 3 cycles, all we = 1 on the 4th; stall_cnt = 3.
4. Timeout: MEM_TIMEOUT = 4, exmem_memwr = 1, dmem_ready held 0 -> mem_err = 1 and halted = 1 after 4 wait cycles; both stay set until reset.
5. Finish: memwb_fin = 1 together with taken = 1 -> no redirect; halted = 1 next cycle; all we stay 0 for 10 or more cycles.
6. Counter saturation and reset: with CNT_W = 2, run 5 load-use stalls -> stall_cnt = 3. Pulse rst_n low mid-MEM_WAIT -> dmem_req = 0 immediately; counters = 0; state RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register enables, bubble flushes, load-use
// stalls, branch redirects, data-memory handshake, halt and performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memrd,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exmem_memrd,
    input  logic             exmem_memwr,
    input  logic             exmem_bbeq,
    input  logic             exmem_bbne,
    input  logic             exmem_bblez,
    input  logic             exmem_bbgtz,
    input  logic             exmem_jump,
    input  logic             exmem_zero,
    input  logic             exmem_negative,
    input  logic             dmem_ready,
    input  logic             memwb_fin,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       pcsrc,
    output logic             dmem_req,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t              state, next_state;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                mem_op, taken, load_use;
    logic                advance, redirect, timeout;

    assign mem_op   = exmem_memrd | exmem_memwr;
    assign taken    = (exmem_bbeq  & exmem_zero)
                    | (exmem_bbne  & ~exmem_zero)
                    | (exmem_bblez & (exmem_zero | exmem_negative))
                    | (exmem_bbgtz & ~exmem_zero & ~exmem_negative)
                    | exmem_jump;
    assign load_use = idex_memrd & (idex_rt != 5'd0)
                    & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state   = state;
        wait_cnt_nxt = wait_cnt;
        advance      = 1'b0;
        redirect     = 1'b0;
        timeout      = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pcsrc        = 2'b00;
        dmem_req     = 1'b0;

        unique case (state)
            RUN: begin
                if (memwb_fin) begin
                    next_state = HALT;
                end else if (mem_op && !dmem_ready) begin
                    dmem_req     = 1'b1;
                    next_state   = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    advance      = 1'b1;
                    next_state   = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
                    timeout    = 1'b1;
                    next_state = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: ;
        endcase

        // A completed access or ordinary cycle advances all stages, then hazards refine it.
        if (advance) begin
            dmem_req = dmem_req | mem_op;
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
            if (taken) begin
                {ifid_flush, idex_flush, exmem_flush} = '1;
                pcsrc    = exmem_jump ? 2'b10 : 2'b01;
                redirect = 1'b1;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (!rst_n) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
            {ifid_flush, idex_flush, exmem_flush}         = '0;
            pcsrc    = 2'b00;
            dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            state    <= next_state;
            wait_cnt <= wait_cnt_nxt;
            if (next_state == HALT) halted <= 1'b1;
            if (timeout) mem_err <= 1'b1;
            if (!pc_we && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and compared once the combinational outputs settle.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int SAT         = (1 << CNT_W) - 1;

    // {pc,ifid,idex,exmem,memwb we | ifid,idex,exmem flush | pcsrc | dmem_req}
    localparam logic [10:0] E_IDLE  = 11'b00000_000_00_0;
    localparam logic [10:0] E_RUN   = 11'b11111_000_00_0;
    localparam logic [10:0] E_WAIT  = 11'b00000_000_00_1;
    localparam logic [10:0] E_LU    = 11'b00111_010_00_0;
    localparam logic [10:0] E_BR    = 11'b11111_111_01_0;
    localparam logic [10:0] E_JMP   = 11'b11111_111_10_0;
    localparam logic [10:0] E_MEMOK = 11'b11111_000_00_1;
    localparam logic [10:0] E_MEMJ  = 11'b11111_111_10_1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic idex_memrd, exmem_memrd, exmem_memwr;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic exmem_bbeq, exmem_bbne, exmem_bblez, exmem_bbgtz, exmem_jump;
    logic exmem_zero, exmem_negative, dmem_ready, memwb_fin;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush, exmem_flush, dmem_req, halted, mem_err;
    logic [1:0] pcsrc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memrd(idex_memrd), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr),
        .exmem_bbeq(exmem_bbeq), .exmem_bbne(exmem_bbne), .exmem_bblez(exmem_bblez),
        .exmem_bbgtz(exmem_bbgtz), .exmem_jump(exmem_jump),
        .exmem_zero(exmem_zero), .exmem_negative(exmem_negative),
        .dmem_ready(dmem_ready), .memwb_fin(memwb_fin),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pcsrc(pcsrc), .dmem_req(dmem_req),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    logic [10:0] obs;
    assign obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                  ifid_flush, idex_flush, exmem_flush, pcsrc, dmem_req};

    typedef struct {
        logic [10:0] outs;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    bit   in_halt = 1'b0;

    task automatic clear_in();
        idex_memrd = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        exmem_memrd = 0; exmem_memwr = 0;
        exmem_bbeq = 0; exmem_bbne = 0; exmem_bblez = 0; exmem_bbgtz = 0; exmem_jump = 0;
        exmem_zero = 0; exmem_negative = 0; dmem_ready = 0; memwb_fin = 0;
    endtask

    // Queue the expected cycle outputs and advance the saturating counter model.
    task automatic push_exp(input logic [10:0] v, input string tag);
        sb.push_back('{v, tag});
        if (!v[10] && !in_halt && exp_stall < SAT) exp_stall++;
        if (v[2:1] != 2'b00 && exp_flush < SAT) exp_flush++;
    endtask

    task automatic apply_reset();
        clear_in();
        rst_n = 1'b0;
        exp_stall = 0; exp_flush = 0; in_halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_in();
        exmem_jump = 1; exmem_memrd = 1; idex_memrd = 1; idex_rt = 5'd3; ifid_rs = 5'd3;
        rst_n = 1'b0;
        sb.push_back('{E_IDLE, "reset_outs"});
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
        checks++;
        if ({halted, mem_err} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b want 00", {halted, mem_err});
        end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [10:0] ev;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            idex_memrd = 1;
            case (i)
                0: begin idex_rt = 5'd5; ifid_rs = 5'd5; ev = E_LU; end
                1: begin idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ev = E_RUN; end
                2: begin idex_rt = 5'd7; ifid_rs = 5'd1; ifid_rt = 5'd7; ev = E_LU; end
                default: begin idex_rt = 5'd5; ifid_rs = 5'd6; ifid_rt = 5'd4; ev = E_RUN; end
            endcase
            push_exp(ev, $sformatf("load_use_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            checks++;
            if (stall_cnt !== CNT_W'(exp_stall)) begin
                errors++; $display("FAIL load_use_stall_cnt_%0d got %0d want %0d", i, stall_cnt, exp_stall);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [10:0] ev;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            clear_in();
            case (i)
                0: begin exmem_bbeq = 1; exmem_zero = 1; ev = E_BR; end
                1: begin exmem_bbne = 1; exmem_zero = 1; ev = E_RUN; end
                2: begin exmem_jump = 1; ev = E_JMP; end
                3: begin exmem_bbeq = 1; ev = E_RUN; end
                4: begin exmem_bblez = 1; exmem_negative = 1; ev = E_BR; end
                5: begin exmem_bbgtz = 1; idex_memrd = 1; idex_rt = 5'd9; ifid_rs = 5'd9; ev = E_BR; end
                6: begin exmem_bbgtz = 1; exmem_negative = 1; ev = E_RUN; end
                default: begin exmem_bbne = 1; ev = E_BR; end
            endcase
            push_exp(ev, $sformatf("branch_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            checks++;
            if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
                errors++;
                $display("FAIL branch_counters_%0d got %0d/%0d want %0d/%0d",
                         i, flush_cnt, stall_cnt, exp_flush, exp_stall);
            end
        end
    endtask

    task automatic test_slow_mem();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            clear_in();
            case (i)
                0, 1, 2: begin exmem_memrd = 1; push_exp(E_WAIT, $sformatf("slow_wait_%0d", i)); end
                3: begin exmem_memrd = 1; dmem_ready = 1; push_exp(E_MEMOK, "slow_done"); end
                4: begin exmem_memwr = 1; push_exp(E_WAIT, "slow_store_wait"); end
                5: begin exmem_memwr = 1; dmem_ready = 1; exmem_jump = 1; push_exp(E_MEMJ, "slow_store_jump"); end
                default: push_exp(E_RUN, "slow_resume");
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            checks++;
            if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush) || halted !== 1'b0) begin
                errors++;
                $display("FAIL slow_state_%0d got stall %0d flush %0d halted %b want %0d %0d 0",
                         i, stall_cnt, flush_cnt, halted, exp_stall, exp_flush);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic want;
        apply_reset();
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            clear_in();
            exmem_memwr = 1;
            push_exp(E_WAIT, $sformatf("timeout_wait_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            want = (i == MEM_TIMEOUT);
            checks++;
            if (mem_err !== want || halted !== want) begin
                errors++;
                $display("FAIL timeout_flags_%0d got err %b halted %b want %b", i, mem_err, halted, want);
            end
        end
        in_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clear_in();
            exmem_memwr = 1; dmem_ready = 1; exmem_jump = 1;
            push_exp(E_IDLE, $sformatf("timeout_halt_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            checks++;
            if (mem_err !== 1'b1 || halted !== 1'b1 || stall_cnt !== CNT_W'(exp_stall)) begin
                errors++;
                $display("FAIL timeout_sticky_%0d got err %b halted %b stall %0d want 1 1 %0d",
                         i, mem_err, halted, stall_cnt, exp_stall);
            end
        end
    endtask

    task automatic test_finish();
        exp_t e;
        apply_reset();
        clear_in();
        memwb_fin = 1; exmem_bbeq = 1; exmem_zero = 1;
        push_exp(E_IDLE, "finish_cycle");
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
        @(negedge clk);
        in_halt = 1'b1;
        checks++;
        if (halted !== 1'b1 || flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
            errors++;
            $display("FAIL finish_state got halted %b flush %0d stall %0d want 1 %0d %0d",
                     halted, flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
        for (int i = 0; i < 11; i++) begin
            clear_in();
            case (i % 3)
                0: exmem_jump = 1;
                1: begin exmem_memrd = 1; dmem_ready = 1; end
                default: begin idex_memrd = 1; idex_rt = 5'd2; ifid_rt = 5'd2; end
            endcase
            push_exp(E_IDLE, $sformatf("finish_hold_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
        end
        checks++;
        if (halted !== 1'b1 || mem_err !== 1'b0 || stall_cnt !== CNT_W'(exp_stall)) begin
            errors++;
            $display("FAIL finish_end got halted %b err %b stall %0d want 1 0 %0d",
                     halted, mem_err, stall_cnt, exp_stall);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            clear_in();
            idex_memrd = 1; idex_rt = 5'd12; ifid_rs = 5'd12;
            push_exp(E_LU, $sformatf("sat_stall_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            @(negedge clk);
            checks++;
            if (stall_cnt !== CNT_W'(exp_stall)) begin
                errors++; $display("FAIL sat_stall_cnt_%0d got %0d want %0d", i, stall_cnt, exp_stall);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            clear_in();
            exmem_memrd = 1;
            push_exp(E_WAIT, $sformatf("midrst_wait_%0d", i));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
            if (i == 0) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        exp_stall = 0; exp_flush = 0;
        sb.push_back('{E_IDLE, "midrst_outs"});
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midrst_regs got stall %0d flush %0d halted %b want 0 0 0", stall_cnt, flush_cnt, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        push_exp(E_RUN, "midrst_run");
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.outs) begin errors++; $display("FAIL %s got %b want %b", e.tag, obs, e.outs); end
        @(negedge clk);
    endtask

    initial begin
        clear_in();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_slow_mem();
        test_timeout();
        test_finish();
        test_saturation();
        test_reset_mid_wait();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
